rcb_contact_monitor: RTL and testbench



---
 rtl/rcb_contact_monitor_pkg.sv | 16 +
 rtl/rcb_contact_chan.sv | 56 +++++
 rtl/rcb_contact_monitor.sv | 58 +++++
 tb/tb_rcb_contact_monitor.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rcb_contact_monitor_pkg.sv
// rcb_contact_monitor_pkg: state encodings, contact codes and code decode for the contact monitor
package rcb_contact_monitor_pkg;
   typedef enum logic [1:0] {
      ST_UNKNOWN  = 2'b00,
      ST_RELEASED = 2'b01,
      ST_PRESSED  = 2'b10,
      ST_FAULT    = 2'b11
   } st_e;
   localparam logic [1:0] CODE_INV = 2'b00;
   localparam logic [1:0] CODE_REL = 2'b01;
   localparam logic [1:0] CODE_PRS = 2'b10;
   // 00 and 11 both collapse to CODE_INV so swapping between them is not a code change
   function automatic logic [1:0] decode(input logic [1:0] code);
      return (code == CODE_REL || code == CODE_PRS) ? code : CODE_INV;
   endfunction
endpackage

// File: rtl/rcb_contact_chan.sv
// rcb_contact_chan: one NC/NO contact channel with sync, debounce, fault detection and sticky events
module rcb_contact_chan
   import rcb_contact_monitor_pkg::*;
#(
   parameter int DEB_TICKS   = 10,
   parameter int FAULT_TICKS = 1000
) (
   input  logic       clk_100m,
   input  logic       rst_n,
   input  logic       tick,
   input  logic       nc,
   input  logic       no,
   input  logic       clr_press,
   input  logic       clr_rel,
   output logic [1:0] state,
   output logic       press_evt,
   output logic       rel_evt,
   output logic       fault
);
   localparam int CW = $clog2(FAULT_TICKS + 1);
   localparam logic [CW-1:0] C_DEB = CW'(DEB_TICKS);
   localparam logic [CW-1:0] C_FLT = CW'(FAULT_TICKS);
   logic [1:0] s1, s2, dec, dec_q;
   logic [CW-1:0] cnt, cnt_nxt;
   logic inv;
   st_e st, st_nxt;
   // state decision uses the post-edge count so state lands on the tick that completes the debounce
   always_comb begin
      dec     = decode(s2);
      inv     = dec == CODE_INV;
      cnt_nxt = (dec != dec_q) ? '0 : (tick && cnt != C_FLT) ? cnt + 1'b1 : cnt;
      st_nxt  = (inv && cnt_nxt == C_FLT && st != ST_FAULT) ? ST_FAULT :
                (!inv && cnt_nxt >= C_DEB && st_e'(dec) != st) ? st_e'(dec) : st;
   end
   always_ff @(posedge clk_100m or negedge rst_n) begin
      if (!rst_n) begin
         s1        <= '0;
         s2        <= '0;
         dec_q     <= CODE_INV;
         cnt       <= '0;
         st        <= ST_UNKNOWN;
         press_evt <= 1'b0;
         rel_evt   <= 1'b0;
      end else begin
         s1        <= {nc, no};
         s2        <= s1;
         dec_q     <= dec;
         cnt       <= cnt_nxt;
         st        <= st_nxt;
         press_evt <= (st_nxt == ST_PRESSED && st != ST_PRESSED) | (press_evt & ~clr_press);
         rel_evt   <= (st_nxt == ST_RELEASED && st != ST_RELEASED) | (rel_evt & ~clr_rel);
      end
   end
   assign state = st;
   assign fault = st == ST_FAULT;
endmodule

// File: rtl/rcb_contact_monitor.sv
// rcb_contact_monitor: N-channel dual-contact switch monitor with shared debounce tick and registered irq
module rcb_contact_monitor
   import rcb_contact_monitor_pkg::*;
#(
   parameter int N_CH        = 12,
   parameter int PRESCALE    = 100,
   parameter int DEB_TICKS   = 10,
   parameter int FAULT_TICKS = 1000
) (
   input  logic              clk_100m,
   input  logic              rst_n,
   input  logic [N_CH-1:0]   nc,
   input  logic [N_CH-1:0]   no,
   input  logic [2*N_CH-1:0] evt_clr,
   input  logic [N_CH-1:0]   irq_mask,
   input  logic              fault_irq_en,
   output logic [2*N_CH-1:0] state,
   output logic [N_CH-1:0]   press_evt,
   output logic [N_CH-1:0]   rel_evt,
   output logic [N_CH-1:0]   fault,
   output logic              irq
);
   localparam int PW = $clog2(PRESCALE + 1);
   localparam logic [PW-1:0] P_LAST = PW'(PRESCALE - 1);
   logic [PW-1:0] pcnt;
   logic tick;
   if (DEB_TICKS < 1 || DEB_TICKS >= FAULT_TICKS) begin : g_bad_deb
      $error("DEB_TICKS must be in 1..FAULT_TICKS-1");
   end
   assign tick = pcnt == P_LAST;
   always_ff @(posedge clk_100m or negedge rst_n) begin
      if (!rst_n) begin
         pcnt <= '0;
         irq  <= 1'b0;
      end else begin
         pcnt <= tick ? '0 : pcnt + 1'b1;
         irq  <= |((press_evt | rel_evt) & irq_mask) | (fault_irq_en & |fault);
      end
   end
   for (genvar i = 0; i < N_CH; i++) begin : g_ch
      rcb_contact_chan #(
         .DEB_TICKS  (DEB_TICKS),
         .FAULT_TICKS(FAULT_TICKS)
      ) u_chan (
         .clk_100m (clk_100m),
         .rst_n    (rst_n),
         .tick     (tick),
         .nc       (nc[i]),
         .no       (no[i]),
         .clr_press(evt_clr[2*i]),
         .clr_rel  (evt_clr[2*i+1]),
         .state    (state[2*i +: 2]),
         .press_evt(press_evt[i]),
         .rel_evt  (rel_evt[i]),
         .fault    (fault[i])
      );
   end
endmodule

// File: tb/tb_rcb_contact_monitor.sv
// tb_rcb_contact_monitor: directed stimulus, per-cycle comparison against a tick-arithmetic model
module tb_rcb_contact_monitor;
   localparam int N = 4;
   localparam int P = 4;
   localparam int DEB = 3;
   localparam int FT = 8;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic [N-1:0] nc = '0;
   logic [N-1:0] no = '1;
   logic [2*N-1:0] evt_clr = '0;
   logic [N-1:0] irq_mask = '0;
   logic fault_irq_en = 1'b0;
   logic [2*N-1:0] state;
   logic [N-1:0] press_evt, rel_evt, fault;
   logic irq;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   rcb_contact_monitor #(
      .N_CH(N), .PRESCALE(P), .DEB_TICKS(DEB), .FAULT_TICKS(FT)
   ) dut (
      .clk_100m(clk), .rst_n(rst_n), .nc(nc), .no(no), .evt_clr(evt_clr),
      .irq_mask(irq_mask), .fault_irq_en(fault_irq_en), .state(state),
      .press_evt(press_evt), .rel_evt(rel_evt), .fault(fault), .irq(irq)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Model: k = clock edges since reset release; a debounce tick lands on every edge k with k%P == 0.
   // Ticks accumulated since the last class change at edge tc are simply k/P - tc/P.
   int k = 0;
   int m_st[N];
   int m_tc[N];
   logic [1:0] p1[N], p2[N], m_cls[N];
   logic [N-1:0] m_pe = '0, m_re = '0;
   logic m_irq = 1'b0;

   function automatic logic [1:0] cls_of(input logic [1:0] c);
      return (c == 2'b01 || c == 2'b10) ? c : 2'b00;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         k = 0;
         m_pe = '0;
         m_re = '0;
         m_irq = 1'b0;
         for (int i = 0; i < N; i++) begin
            m_st[i] = 0; m_tc[i] = 0; p1[i] = '0; p2[i] = '0; m_cls[i] = '0;
         end
      end else begin
         logic [N-1:0] flt;
         k++;
         for (int i = 0; i < N; i++) flt[i] = (m_st[i] == 3);
         m_irq = |((m_pe | m_re) & irq_mask) | (fault_irq_en & |flt);
         for (int i = 0; i < N; i++) begin
            logic [1:0] c;
            int run;
            logic sp, sr;
            c = cls_of(p2[i]);
            p2[i] = p1[i];
            p1[i] = {nc[i], no[i]};
            if (c != m_cls[i]) begin
               m_cls[i] = c;
               m_tc[i] = k;
            end
            run = k / P - m_tc[i] / P;
            if (run > FT) run = FT;
            sp = 1'b0;
            sr = 1'b0;
            if (c == 2'b00) begin
               if (run >= FT && m_st[i] != 3) m_st[i] = 3;
            end else if (run >= DEB && m_st[i] != int'(c)) begin
               m_st[i] = int'(c);
               sp = (c == 2'b10);
               sr = (c == 2'b01);
            end
            m_pe[i] = sp | (m_pe[i] & ~evt_clr[2*i]);
            m_re[i] = sr | (m_re[i] & ~evt_clr[2*i+1]);
         end
      end
   end

   initial begin
      forever begin
         @(posedge clk);
         #1;
         begin
            logic [2*N-1:0] es;
            logic [N-1:0] ef;
            for (int i = 0; i < N; i++) begin
               es[2*i +: 2] = m_st[i][1:0];
               ef[i] = (m_st[i] == 3);
            end
            chk("cmp_state", 32'(state), 32'(es));
            chk("cmp_press_evt", 32'(press_evt), 32'(m_pe));
            chk("cmp_rel_evt", 32'(rel_evt), 32'(m_re));
            chk("cmp_fault", 32'(fault), 32'(ef));
            chk("cmp_irq", 32'(irq), 32'(m_irq));
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog_timeout actual=running expected=finished");
      $fatal(1);
   end

   task automatic drive(input int ch, input logic [1:0] c);
      nc[ch] = c[1];
      no[ch] = c[0];
   endtask

   task automatic pulse(input logic [2*N-1:0] v);
      evt_clr = v;
      @(negedge clk);
      evt_clr = '0;
   endtask

   task automatic wait_state(input int ch, input logic [1:0] v, output int n);
      n = 0;
      while (state[2*ch +: 2] !== v && n < 40) begin
         @(negedge clk);
         n++;
      end
   endtask

   int n, trans, tgt;
   logic [1:0] prev2;

   task automatic watch2(input int cyc);
      repeat (cyc) begin
         @(negedge clk);
         if (state[5:4] !== prev2) begin
            trans++;
            prev2 = state[5:4];
         end
      end
   endtask

   initial begin
      repeat (3) @(negedge clk);
      chk("rst_state", 32'(state), 0);
      chk("rst_events", 32'({press_evt, rel_evt}), 0);
      chk("rst_irq", 32'(irq), 0);
      rst_n = 1'b1;
      wait_state(0, 2'b01, n);
      chk("rel_latency_in_range", 32'(n >= 12 && n <= 19), 1);
      chk("all_released", 32'(state), 32'h55);
      chk("ch0_rel_evt", 32'(rel_evt[0]), 1);
      chk("ch0_press_evt", 32'(press_evt[0]), 0);
      pulse(8'hAA);
      chk("rel_cleared", 32'(rel_evt), 0);

      irq_mask = 4'b0010;
      drive(1, 2'b10);
      wait_state(1, 2'b10, n);
      chk("press_latency_in_range", 32'(n >= 12 && n <= 19), 1);
      chk("ch1_press_evt", 32'(press_evt[1]), 1);
      chk("irq_lags_event", 32'(irq), 0);
      @(negedge clk);
      chk("irq_after_press", 32'(irq), 1);
      pulse(8'h04);
      @(negedge clk);
      chk("irq_after_clear", 32'(irq), 0);

      irq_mask = 4'b0000;
      trans = 0;
      prev2 = state[5:4];
      for (int j = 0; j < 10; j++) begin
         drive(2, (j % 2 == 1) ? 2'b01 : 2'b10);
         watch2(6);
      end
      drive(2, 2'b10);
      watch2(30);
      chk("bounce_transitions", 32'(trans), 1);
      chk("bounce_final_state", 32'(state[5:4]), 2);
      chk("bounce_press_evt", 32'(press_evt[2]), 1);
      chk("bounce_no_rel_evt", 32'(rel_evt[2]), 0);

      pulse(8'hFF);
      fault_irq_en = 1'b1;
      drive(3, 2'b11);
      repeat (40) @(negedge clk);
      chk("fault_flag", 32'(fault), 32'h8);
      chk("fault_state", 32'(state[7:6]), 3);
      chk("fault_irq", 32'(irq), 1);
      chk("fault_no_events", 32'({press_evt[3], rel_evt[3]}), 0);
      drive(3, 2'b01);
      wait_state(3, 2'b01, n);
      chk("fault_exit_latency", 32'(n >= 12 && n <= 19), 1);
      chk("fault_exit_rel_evt", 32'(rel_evt[3]), 1);
      chk("fault_cleared", 32'(fault), 0);
      @(negedge clk);
      fault_irq_en = 1'b0;

      pulse(8'hFF);
      irq_mask = 4'b0010;
      drive(1, 2'b01);
      wait_state(1, 2'b01, n);
      pulse(8'hFF);
      @(negedge clk);
      drive(1, 2'b10);
      tgt = P * ((k + 3) / P + DEB);
      while (k < tgt - 1) @(negedge clk);
      chk("race_pre_state", 32'(state[3:2]), 1);
      evt_clr = 8'h04;
      @(negedge clk);
      evt_clr = '0;
      chk("race_state", 32'(state[3:2]), 2);
      chk("race_set_wins", 32'(press_evt[1]), 1);
      @(negedge clk);
      chk("race_irq", 32'(irq), 1);
      pulse(8'h04);
      chk("race_later_clear", 32'(press_evt[1]), 0);
      @(negedge clk);
      chk("race_irq_drop", 32'(irq), 0);

      drive(1, 2'b01);
      repeat (8) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("async_rst_state", 32'(state), 0);
      chk("async_rst_events", 32'({press_evt, rel_evt, fault}), 0);
      chk("async_rst_irq", 32'(irq), 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (8) @(negedge clk);
      chk("post_rst_no_evt", 32'(rel_evt), 0);
      chk("post_rst_unknown", 32'(state), 0);
      wait_state(1, 2'b01, n);
      chk("post_rst_latency", 32'(n + 8 >= 12 && n + 8 <= 19), 1);
      chk("post_rst_rel_evt", 32'(rel_evt[1]), 1);
      repeat (3) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
